// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: turns a stream of calculator key codes into operand/operation
// pairs for a downstream ALU, then waits for that ALU to finish.
// Optional feature: define CALC_KEY_TIMEOUT_EN to add a 16-cycle watchdog on the
// ALU handshake; without it the sequencer waits indefinitely for alu_valid.
module calc_key_sequencer #(
   parameter int inSize = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_valid,
   input  logic [4:0]        key_code,
   input  logic              alu_valid,
   output logic              alu_en,
   output logic [1:0]        operation,
   output logic [inSize-1:0] A,
   output logic [inSize-1:0] B,
   output logic              busy,
   output logic              err
);

   // Accumulator width: max*10+9 always fits in four extra bits.
   localparam int WW = inSize + 4;

   typedef enum logic [2:0] {ENTER_A, ENTER_B, ISSUE, WAIT, DONE} state_t;

   state_t            state_reg, state_next;
   logic [inSize-1:0] a_reg, a_next;
   logic [inSize-1:0] b_reg, b_next;
   logic [1:0]        op_reg, op_next;
   logic              err_reg, err_next;
   logic              b_seen_reg, b_seen_next;   // at least one B digit accepted
`ifdef CALC_KEY_TIMEOUT_EN
   logic [3:0]        wd_reg, wd_next;
`endif

   logic          is_digit, is_op, is_eq, is_clr;
   logic [WW-1:0] digit_ext, acc_a, acc_b;
   logic          ovf_a, ovf_b;

   // Key decode and decimal accumulation for both operands.
   always_comb begin
      is_digit  = key_valid && (key_code <= 5'd9);
      is_op     = key_valid && (key_code[4:2] == 3'b100);
      is_eq     = key_valid && (key_code == 5'h14);
      is_clr    = key_valid && (key_code == 5'h15);
      digit_ext = {{inSize{1'b0}}, key_code[3:0]};
      acc_a     = ({4'b0, a_reg} * WW'(10)) + digit_ext;
      acc_b     = ({4'b0, b_reg} * WW'(10)) + digit_ext;
      ovf_a     = |acc_a[WW-1:inSize];
      ovf_b     = |acc_b[WW-1:inSize];
   end

   // Next-state and datapath updates; clear overrides everything else.
   always_comb begin
      state_next  = state_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      op_next     = op_reg;
      err_next    = err_reg;
      b_seen_next = b_seen_reg;
`ifdef CALC_KEY_TIMEOUT_EN
      wd_next     = wd_reg;
`endif
      case (state_reg)
         ENTER_A: begin
            if (is_digit) begin
               if (ovf_a) err_next = 1'b1;
               else       a_next   = acc_a[inSize-1:0];
            end else if (is_op) begin
               op_next     = key_code[1:0];
               b_next      = '0;
               b_seen_next = 1'b0;
               state_next  = ENTER_B;
            end
         end
         ENTER_B: begin
            if (is_digit) begin
               if (ovf_b) begin
                  err_next = 1'b1;
               end else begin
                  b_next      = acc_b[inSize-1:0];
                  b_seen_next = 1'b1;
               end
            end else if (is_op) begin
               // The operator may only be changed until the second operand starts.
               if (!b_seen_reg) op_next = key_code[1:0];
            end else if (is_eq) begin
               if (op_reg == 2'b11 && b_reg == '0) begin
                  err_next   = 1'b1;
                  a_next     = '0;
                  b_next     = '0;
                  state_next = ENTER_A;
               end else begin
                  state_next = ISSUE;
               end
            end
         end
         ISSUE: begin
            state_next = WAIT;
`ifdef CALC_KEY_TIMEOUT_EN
            wd_next    = '0;
`endif
         end
         WAIT: begin
            if (alu_valid) begin
               state_next = DONE;
            end else begin
`ifdef CALC_KEY_TIMEOUT_EN
               if (wd_reg == 4'd15) begin
                  err_next   = 1'b1;
                  a_next     = '0;
                  b_next     = '0;
                  wd_next    = '0;
                  state_next = ENTER_A;
               end else begin
                  wd_next = wd_reg + 4'd1;
               end
`endif
            end
         end
         DONE: begin
            // A digit starts a fresh calculation; operators and equals are ignored.
            if (is_digit) begin
               a_next      = digit_ext[inSize-1:0];
               b_next      = '0;
               err_next    = 1'b0;
               b_seen_next = 1'b0;
               state_next  = ENTER_A;
            end
         end
         default: state_next = ENTER_A;
      endcase
      if (is_clr) begin
         state_next  = ENTER_A;
         a_next      = '0;
         b_next      = '0;
         op_next     = 2'b00;
         err_next    = 1'b0;
         b_seen_next = 1'b0;
`ifdef CALC_KEY_TIMEOUT_EN
         wd_next     = '0;
`endif
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= ENTER_A;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= 2'b00;
         err_reg    <= 1'b0;
         b_seen_reg <= 1'b0;
`ifdef CALC_KEY_TIMEOUT_EN
         wd_reg     <= '0;
`endif
      end else begin
         state_reg  <= state_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         op_reg     <= op_next;
         err_reg    <= err_next;
         b_seen_reg <= b_seen_next;
`ifdef CALC_KEY_TIMEOUT_EN
         wd_reg     <= wd_next;
`endif
      end
   end

   // Outputs are decoded straight from registers so reset clears them at once.
   always_comb begin
      alu_en    = (state_reg == ISSUE);
      busy      = (state_reg == ISSUE) || (state_reg == WAIT);
      operation = op_reg;
      A         = a_reg;
      B         = b_reg;
      err       = err_reg;
   end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Testbench for calc_key_sequencer (8-bit operands): table-driven key vectors,
// hand-written reset/watchdog sequences, and a scoreboard of expected ALU issues.
module tb_calc_key_sequencer;

   localparam int W = 8;
   localparam logic [4:0] K_ADD = 5'h10, K_SUB = 5'h11, K_MUL = 5'h12,
                          K_DIV = 5'h13, K_EQ = 5'h14, K_CLR = 5'h15;

   typedef struct {
      logic         kv;
      logic [4:0]   kc;
      logic         av;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;
      logic         busy;
      logic         err;
      logic         en;
   } vec_t;

   typedef struct packed {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } issue_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_valid;
   logic [4:0]   key_code;
   logic         alu_valid;
   logic         alu_en;
   logic [1:0]   operation;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         busy;
   logic         err;

   int     n_checks = 0;
   int     n_fail   = 0;
   vec_t   vecs[$];
   issue_t sb[$];

   calc_key_sequencer #(.inSize(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .alu_valid (alu_valid),
      .alu_en    (alu_en),
      .operation (operation),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic kv, input logic [4:0] kc, input logic av,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] op, input logic bz, input logic er,
                               input logic en);
      vec_t v;
      v.kv = kv; v.kc = kc; v.av = av; v.a = a; v.b = b;
      v.op = op; v.busy = bz; v.err = er; v.en = en;
      return v;
   endfunction

   function automatic issue_t mki(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      issue_t e;
      e.op = op; e.a = a; e.b = b;
      return e;
   endfunction

   // Called at a falling edge: drive one cycle of inputs, land on the next falling edge.
   task automatic step(input logic kv, input logic [4:0] kc, input logic av);
      key_valid = kv;
      key_code  = kc;
      alu_valid = av;
      @(posedge clk);
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 5'h00;
      alu_valid = 1'b0;
   endtask

   // Scoreboard: every alu_en pulse must match the oldest expected issue.
   always @(negedge clk) begin
      if (rst === 1'b1 && alu_en === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_alu_en: got pulse expected none (A=%0d B=%0d op=%0d)",
                     A, B, operation);
         end else begin
            issue_t e;
            e = sb.pop_front();
            chk("sb_A", 32'(A), 32'(e.a));
            chk("sb_B", 32'(B), 32'(e.b));
            chk("sb_op", 32'(operation), 32'(e.op));
            $display("issue: A=%0d B=%0d op=%0d", A, B, operation);
         end
      end
   end

   initial begin
      rst = 1'b0; key_valid = 1'b0; key_code = 5'h00; alu_valid = 1'b0;

      // 1,2,add,3,= then ALU handshake, DONE behaviour
      vecs.push_back(mk(1, 5'd1, 0,  1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5'd2, 0, 12, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, K_ADD, 0, 12, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5'd3, 0, 12, 3, 0, 0, 0, 0));
      vecs.push_back(mk(1, K_EQ, 0, 12, 3, 0, 1, 0, 1));
      vecs.push_back(mk(0, 5'd0, 0, 12, 3, 0, 1, 0, 0));
      vecs.push_back(mk(1, 5'd7, 0, 12, 3, 0, 1, 0, 0));
      vecs.push_back(mk(0, 5'd0, 1, 12, 3, 0, 0, 0, 0));
      vecs.push_back(mk(0, 5'd0, 1, 12, 3, 0, 0, 0, 0));
      vecs.push_back(mk(1, K_ADD, 0, 12, 3, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5'd5, 0,  5, 0, 0, 0, 0, 0));
      // 5,add,sub,2,mul,= : operator replaced before B digit, ignored after
      vecs.push_back(mk(1, K_ADD, 0, 5, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, K_SUB, 0, 5, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 5'd2, 0, 5, 2, 1, 0, 0, 0));
      vecs.push_back(mk(1, K_MUL, 0, 5, 2, 1, 0, 0, 0));
      vecs.push_back(mk(1, K_EQ, 0, 5, 2, 1, 1, 0, 1));
      vecs.push_back(mk(0, 5'd0, 1, 5, 2, 1, 1, 0, 0));
      vecs.push_back(mk(0, 5'd0, 1, 5, 2, 1, 0, 0, 0));
      vecs.push_back(mk(1, K_CLR, 0, 0, 0, 0, 0, 0, 0));
      // overflow boundary: 255 fits, 2551 does not
      vecs.push_back(mk(1, 5'd2, 0,   2, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5'd5, 0,  25, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5'd5, 0, 255, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5'd1, 0, 255, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, K_CLR, 0,  0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5'd2, 0,   2, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5'd5, 0,  25, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5'd6, 0,  25, 0, 0, 0, 1, 0));
      // err stays sticky through a full calculation, first DONE digit clears it
      vecs.push_back(mk(1, K_ADD, 0, 25, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, K_EQ, 0, 25, 0, 0, 1, 1, 1));
      vecs.push_back(mk(0, 5'd0, 0, 25, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 5'd0, 1, 25, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 5'd4, 0,  4, 0, 0, 0, 0, 0));
      // 8,div,0,= : divide by zero, no issue, back to operand A entry
      vecs.push_back(mk(1, K_CLR, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5'd8, 0, 8, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, K_DIV, 0, 8, 0, 3, 0, 0, 0));
      vecs.push_back(mk(1, 5'd0, 0, 8, 0, 3, 0, 0, 0));
      vecs.push_back(mk(1, K_EQ, 0, 0, 0, 3, 0, 1, 0));
      vecs.push_back(mk(1, 5'd3, 0, 3, 0, 3, 0, 1, 0));
      vecs.push_back(mk(1, K_EQ, 0, 3, 0, 3, 0, 1, 0));
      // clear during WAIT, later alu_valid ignored
      vecs.push_back(mk(1, K_CLR, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5'd9, 0, 9, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, K_MUL, 0, 9, 0, 2, 0, 0, 0));
      vecs.push_back(mk(1, 5'd7, 0, 9, 7, 2, 0, 0, 0));
      vecs.push_back(mk(1, K_EQ, 0, 9, 7, 2, 1, 0, 1));
      vecs.push_back(mk(0, 5'd0, 0, 9, 7, 2, 1, 0, 0));
      vecs.push_back(mk(1, K_CLR, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 5'd0, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5'd4, 0, 4, 0, 0, 0, 0, 0));
      // undefined codes are ignored
      vecs.push_back(mk(1, 5'h0A, 0, 4, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5'h1F, 0, 4, 0, 0, 0, 0, 0));

      // reset state
      #1;
      chk("rst_A", 32'(A), 0);
      chk("rst_B", 32'(B), 0);
      chk("rst_op", 32'(operation), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_alu_en", 32'(alu_en), 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].en) sb.push_back(mki(vecs[i].op, vecs[i].a, vecs[i].b));
         step(vecs[i].kv, vecs[i].kc, vecs[i].av);
         chk($sformatf("v%0d_A", i), 32'(A), 32'(vecs[i].a));
         chk($sformatf("v%0d_B", i), 32'(B), 32'(vecs[i].b));
         chk($sformatf("v%0d_op", i), 32'(operation), 32'(vecs[i].op));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
         chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
         chk($sformatf("v%0d_alu_en", i), 32'(alu_en), 32'(vecs[i].en));
         $display("vec %0d: key=%0b/%0h alu_valid=%0b -> A=%0d B=%0d op=%0d busy=%0b err=%0b en=%0b",
                  i, vecs[i].kv, vecs[i].kc, vecs[i].av, A, B, operation, busy, err, alu_en);
      end

      // watchdog: issue 4+1 and never answer
      step(1, K_ADD, 0);
      step(1, 5'd1, 0);
      sb.push_back(mki(2'b00, 8'd4, 8'd1));
      step(1, K_EQ, 0);
      chk("wd_issue_en", 32'(alu_en), 1);
      for (int k = 0; k < 16; k++) step(0, 5'd0, 0);
      chk("wd_busy_at_16", 32'(busy), 1);
      step(0, 5'd0, 0);
`ifdef CALC_KEY_TIMEOUT_EN
      chk("wd_busy_after", 32'(busy), 0);
      chk("wd_err_after", 32'(err), 1);
      chk("wd_A_after", 32'(A), 0);
      chk("wd_B_after", 32'(B), 0);
`else
      chk("wd_busy_after", 32'(busy), 1);
      chk("wd_err_after", 32'(err), 0);
`endif
      $display("watchdog: busy=%0b err=%0b A=%0d B=%0d", busy, err, A, B);

      // reset in the middle of WAIT, with err set beforehand
      step(1, K_CLR, 0);
      chk("pre_rst_clear_busy", 32'(busy), 0);
      step(1, 5'd2, 0);
      step(1, 5'd5, 0);
      step(1, 5'd6, 0);
      chk("pre_rst_err", 32'(err), 1);
      step(1, K_ADD, 0);
      step(1, 5'd1, 0);
      sb.push_back(mki(2'b00, 8'd25, 8'd1));
      step(1, K_EQ, 0);
      step(0, 5'd0, 0);
      chk("pre_rst_busy", 32'(busy), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_A", 32'(A), 0);
      chk("arst_B", 32'(B), 0);
      chk("arst_op", 32'(operation), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_err", 32'(err), 0);
      chk("arst_alu_en", 32'(alu_en), 0);
      $display("async reset: A=%0d B=%0d op=%0d busy=%0b err=%0b en=%0b",
               A, B, operation, busy, err, alu_en);
      @(negedge clk);
      alu_valid = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      step(0, 5'd0, 1);
      chk("post_rst_av_busy", 32'(busy), 0);
      chk("post_rst_av_A", 32'(A), 0);
      step(1, 5'd7, 0);
      chk("post_rst_first_key", 32'(A), 7);
      $display("post reset: A=%0d busy=%0b", A, busy);

      chk("sb_drained", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
